// File: rtl/mesure_echo.sv
// Echo-timing stage: issues the sensor trigger, times the echo in divider ticks,
// and publishes Distance/Valid or Timeout. Define MESURE_AVG_EN for a 4-sample mean.
module mesure_echo #(
  parameter int unsigned TRIG_CYCLES   = 500,
  parameter int unsigned TIMEOUT_TICKS = 400,
  parameter int unsigned HOLDOFF_TICKS = 1000,
  parameter int unsigned DIST_W        = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Tick,
  input  logic              Start,
  input  logic              Echo,
  output logic              Trig,
  output logic [DIST_W-1:0] Distance,
  output logic              Valid,
  output logic              Timeout,
  output logic              Busy
);

  localparam int unsigned CYC_W  = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLDOFF_TICKS + 1);

  localparam logic [CYC_W-1:0]  TRIG_LAST = CYC_W'(TRIG_CYCLES - 1);
  localparam logic [DIST_W-1:0] TO_MAX    = DIST_W'(TIMEOUT_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    COUNT,
    HOLDOFF
  } state_t;

  state_t state, state_d;

  logic              tick_q, tick_en;
  logic              echo_m, echo_s, echo_q, echo_rise;
  logic [CYC_W-1:0]  cyc_cnt, cyc_cnt_d;
  logic [DIST_W-1:0] tick_cnt, tick_cnt_d, tick_inc;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              valid_d, timeout_d;
  logic [DIST_W-1:0] dist_d;

  assign tick_en   = Tick & ~tick_q;
  assign echo_rise = echo_s & ~echo_q;
  assign tick_inc  = tick_cnt + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    cyc_cnt_d  = cyc_cnt;
    tick_cnt_d = tick_cnt;
    hold_cnt_d = hold_cnt;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    unique case (state)
      IDLE: begin
        cyc_cnt_d  = '0;
        tick_cnt_d = '0;
        hold_cnt_d = '0;
        if (Start) state_d = TRIG;
      end
      TRIG: begin
        if (cyc_cnt == TRIG_LAST) begin
          state_d    = WAIT_RISE;
          tick_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt + 1'b1;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d    = COUNT;
          tick_cnt_d = '0;
        end else if (tick_en) begin
          tick_cnt_d = tick_inc;
          if (tick_inc == TO_MAX) begin
            timeout_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = HOLDOFF;
          end
        end
      end
      COUNT: begin
        // Echo fall is checked first so it beats a coincident tick or timeout.
        if (!echo_s) begin
          valid_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = HOLDOFF;
        end else if (tick_en) begin
          tick_cnt_d = tick_inc;
          if (tick_inc == TO_MAX) begin
            timeout_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (tick_en) begin
          if (hold_cnt == HOLD_LAST) state_d = IDLE;
          else                       hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MESURE_AVG_EN
  logic [DIST_W-1:0] hist [3];
  logic              hist_full;
  logic [DIST_W+1:0] avg_sum;

  // Until the first result lands, the history reads as copies of the new count.
  always_comb begin
    avg_sum = {2'b00, tick_cnt};
    for (int unsigned k = 0; k < 3; k++)
      avg_sum += {2'b00, (hist_full ? hist[k] : tick_cnt)};
  end

  assign dist_d = avg_sum[DIST_W+1:2];

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      hist_full <= 1'b0;
      for (int unsigned k = 0; k < 3; k++) hist[k] <= '0;
    end else if (valid_d) begin
      hist_full <= 1'b1;
      hist[0]   <= tick_cnt;
      hist[1]   <= hist_full ? hist[0] : tick_cnt;
      hist[2]   <= hist_full ? hist[1] : tick_cnt;
    end
  end
`else
  assign dist_d = tick_cnt;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      tick_q   <= 1'b0;
      echo_m   <= 1'b0;
      echo_s   <= 1'b0;
      echo_q   <= 1'b0;
      cyc_cnt  <= '0;
      tick_cnt <= '0;
      hold_cnt <= '0;
      Trig     <= 1'b0;
      Busy     <= 1'b0;
      Valid    <= 1'b0;
      Timeout  <= 1'b0;
      Distance <= '0;
    end else begin
      tick_q   <= Tick;
      echo_m   <= Echo;
      echo_s   <= echo_m;
      echo_q   <= echo_s;
      cyc_cnt  <= cyc_cnt_d;
      tick_cnt <= tick_cnt_d;
      hold_cnt <= hold_cnt_d;
      Trig     <= (state == TRIG);
      Busy     <= (state != IDLE);
      Valid    <= valid_d;
      Timeout  <= timeout_d;
      if (valid_d) Distance <= dist_d;
    end
  end

endmodule
